// File: rtl/freq_pkg.sv
// ============================================================================
// Module : freq_pkg
// Brief  : Shared types and constants for the frequency sweep / tracking
//          logic: sweep state encoding, frequency and ADC widths, counter
//          widths and default parameter values.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_pkg;

  localparam int FREQ_W   = 20;  // frequency word width (Hz)
  localparam int ADC_W    = 12;  // ADC sample width
  localparam int SETTLE_W = 24;  // settle counter width
  localparam int RETUNE_W = 28;  // retune counter width

  localparam logic [FREQ_W-1:0]   F_START_DEF    = 20'd100000;
  localparam logic [FREQ_W-1:0]   F_STOP_DEF     = 20'd120000;
  localparam logic [FREQ_W-1:0]   F_STEP_DEF     = 20'd1000;
  localparam logic [SETTLE_W-1:0] SETTLE_CYC_DEF = 24'h30D40;
  localparam int                  AVG_LOG2_DEF   = 3;
  localparam logic [ADC_W-1:0]    ADC_MIN_DEF    = 12'd64;
  localparam logic [RETUNE_W-1:0] RETUNE_CYC_DEF = 28'd100000000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_EVAL    = 3'd3,
    ST_STEP    = 3'd4,
    ST_LOCK    = 3'd5,
    ST_WAIT_RT = 3'd6
  } sweep_state_t;

  // A sweep point is in progress.
  function automatic logic state_is_busy(input sweep_state_t s);
    return (s == ST_SETTLE) || (s == ST_ACCUM) || (s == ST_EVAL) || (s == ST_STEP);
  endfunction

  // The power stage is parked on a good frequency.
  function automatic logic state_is_locked(input sweep_state_t s);
    return (s == ST_LOCK) || (s == ST_WAIT_RT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_avg_accum.sv
// ============================================================================
// Module : freq_avg_accum
// Brief  : Sums 2^AVG_LOG2 qualified ADC samples and presents the average.
// Ports  : clk         - system clock, rising edge
//          nrst        - synchronous active-low reset
//          clr_i       - clear accumulator and sample count
//          en_i        - accept samples this cycle
//          adc_i       - ADC sample
//          adc_valid_i - sample qualifier
//          avg_o       - accumulator >> AVG_LOG2
//          last_o      - next accepted sample completes the set
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_avg_accum
  import freq_pkg::*;
#(
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ADC_W-1:0] adc_i,
  input  logic             adc_valid_i,
  output logic [ADC_W-1:0] avg_o,
  output logic             last_o
);

  localparam int ACC_W = ADC_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [AVG_LOG2-1:0] cnt_q;

  // Exactly 2^AVG_LOG2 samples are summed, so ACC_W bits never overflow.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (en_i && adc_valid_i) begin
      acc_q <= acc_q + ACC_W'(adc_i);
      cnt_q <= cnt_q + AVG_LOG2'(1);
    end
  end

  // Dropping the low AVG_LOG2 bits is the divide by the sample count.
  assign avg_o  = acc_q[ACC_W-1:AVG_LOG2];
  // Count wraps back to zero on the final sample of the set.
  assign last_o = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/freq_sweep_ctrl.sv
// ============================================================================
// Module : freq_sweep_ctrl
// Brief  : Sweeps the power-stage frequency from F_START to F_STOP in F_STEP
//          increments, averages the rectified voltage at each point and locks
//          onto the frequency with the highest average. Optional periodic
//          resweep while locked.
// Ports  : clk         - system clock, rising edge
//          nrst        - synchronous active-low reset
//          swipt_alive - link present; low aborts to IDLE
//          start       - one-cycle sweep request
//          retune_en   - enables periodic resweep from LOCK
//          adc         - rectified-voltage sample
//          adc_valid   - adc qualifier
//          freq_out    - frequency driven to the power stage
//          best_adc    - best average of the last completed sweep
//          busy        - sweep in progress
//          locked      - parked on the best frequency
//          sweep_done  - one-cycle pulse at sweep end
//          err         - last sweep's best average was below ADC_MIN
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_sweep_ctrl
  import freq_pkg::*;
#(
  parameter logic [FREQ_W-1:0]   F_START    = F_START_DEF,
  parameter logic [FREQ_W-1:0]   F_STOP     = F_STOP_DEF,
  parameter logic [FREQ_W-1:0]   F_STEP     = F_STEP_DEF,
  parameter logic [SETTLE_W-1:0] SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int                  AVG_LOG2   = AVG_LOG2_DEF,
  parameter logic [ADC_W-1:0]    ADC_MIN    = ADC_MIN_DEF,
  parameter logic [RETUNE_W-1:0] RETUNE_CYC = RETUNE_CYC_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              swipt_alive,
  input  logic              start,
  input  logic              retune_en,
  input  logic [ADC_W-1:0]  adc,
  input  logic              adc_valid,
  output logic [FREQ_W-1:0] freq_out,
  output logic [ADC_W-1:0]  best_adc,
  output logic              busy,
  output logic              locked,
  output logic              sweep_done,
  output logic              err
);

  sweep_state_t        state_q,      state_d;
  logic [FREQ_W-1:0]   freq_q,       freq_d;
  logic [ADC_W-1:0]    best_adc_q,   best_adc_d;
  logic [ADC_W-1:0]    best_avg_q,   best_avg_d;
  logic [FREQ_W-1:0]   best_freq_q,  best_freq_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [RETUNE_W-1:0] rt_cnt_q,     rt_cnt_d;
  logic                err_q,        err_d;
  logic                done_q,       done_d;
  logic                busy_q;
  logic                locked_q;

  logic                begin_sweep;
  logic                acc_clr;
  logic                acc_en;
  logic [ADC_W-1:0]    acc_avg;
  logic                acc_last;

  // One extra bit so a step past the top of the 20-bit range is still seen
  // as exceeding F_STOP rather than wrapping.
  logic [FREQ_W:0]     next_freq;
  assign next_freq = {1'b0, freq_q} + {1'b0, F_STEP};

  freq_avg_accum #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk         (clk),
    .nrst        (nrst),
    .clr_i       (acc_clr),
    .en_i        (acc_en),
    .adc_i       (adc),
    .adc_valid_i (adc_valid),
    .avg_o       (acc_avg),
    .last_o      (acc_last)
  );

  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    best_adc_d   = best_adc_q;
    best_avg_d   = best_avg_q;
    best_freq_d  = best_freq_q;
    settle_cnt_d = settle_cnt_q;
    rt_cnt_d     = rt_cnt_q;
    err_d        = err_q;
    done_d       = 1'b0;
    begin_sweep  = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;

    if (!swipt_alive) begin
      // Link loss beats everything, including a coincident start.
      state_d      = ST_IDLE;
      freq_d       = F_START;
      settle_cnt_d = '0;
      rt_cnt_d     = '0;
      acc_clr      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin_sweep = 1'b1;
        end

        ST_SETTLE: begin
          if (settle_cnt_q == '0) state_d = ST_ACCUM;
          else                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end

        ST_ACCUM: begin
          acc_en = 1'b1;
          if (adc_valid && acc_last) state_d = ST_EVAL;
        end

        ST_EVAL: begin
          // Strict compare: on a tie the lower frequency already held wins.
          if (acc_avg > best_avg_q) begin
            best_avg_d  = acc_avg;
            best_freq_d = freq_q;
          end
          state_d = ST_STEP;
        end

        ST_STEP: begin
          if (next_freq <= {1'b0, F_STOP}) begin
            freq_d       = next_freq[FREQ_W-1:0];
            settle_cnt_d = SETTLE_CYC;
            acc_clr      = 1'b1;
            state_d      = ST_SETTLE;
          end else begin
            done_d     = 1'b1;
            best_adc_d = best_avg_q;
            acc_clr    = 1'b1;
            if (best_avg_q >= ADC_MIN) begin
              freq_d  = best_freq_q;
              err_d   = 1'b0;
              state_d = ST_LOCK;
            end else begin
              freq_d  = F_START;
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end

        ST_LOCK: begin
          if (start) begin
            begin_sweep = 1'b1;
          end else if (retune_en) begin
            rt_cnt_d = RETUNE_CYC;
            state_d  = ST_WAIT_RT;
          end
        end

        ST_WAIT_RT: begin
          // Dropping retune_en cancels a pending resweep unless start is
          // also asserted.
          if (start || (retune_en && rt_cnt_q == '0)) begin
            begin_sweep = 1'b1;
          end else if (!retune_en) begin
            rt_cnt_d = '0;
            state_d  = ST_LOCK;
          end else begin
            rt_cnt_d = rt_cnt_q - RETUNE_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          freq_d  = F_START;
        end
      endcase

      if (begin_sweep) begin
        freq_d       = F_START;
        best_avg_d   = '0;
        best_freq_d  = F_START;
        err_d        = 1'b0;
        settle_cnt_d = SETTLE_CYC;
        rt_cnt_d     = '0;
        acc_clr      = 1'b1;
        state_d      = ST_SETTLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      freq_q       <= F_START;
      best_adc_q   <= '0;
      best_avg_q   <= '0;
      best_freq_q  <= F_START;
      settle_cnt_q <= '0;
      rt_cnt_q     <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      best_adc_q   <= best_adc_d;
      best_avg_q   <= best_avg_d;
      best_freq_q  <= best_freq_d;
      settle_cnt_q <= settle_cnt_d;
      rt_cnt_q     <= rt_cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      // Status flags decode the next state so they line up with it.
      busy_q       <= state_is_busy(state_d);
      locked_q     <= state_is_locked(state_d);
    end
  end

  assign freq_out   = freq_q;
  assign best_adc   = best_adc_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign sweep_done = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
// ============================================================================
// Module : tb_freq_sweep_ctrl
// Brief  : Self-checking bench for freq_sweep_ctrl. Full sweeps are driven
//          from a table of per-point sample pairs with hand-computed
//          results; abort, retune and reset corner cases are hand-written.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_freq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swipt_alive = 1'b0;
  logic        start = 1'b0;
  logic        retune_en = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc = '0;
  logic [19:0] freq_out;
  logic [11:0] best_adc;
  logic        busy;
  logic        locked;
  logic        sweep_done;
  logic        err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [5:0][11:0] s;      // two samples for each of points 100,102,104
    bit               junk;   // drive adc_valid with 4095 throughout SETTLE
    int               best;   // expected best_adc
    int               freq;   // expected final freq_out
    bit               lk;     // expected locked
    bit               er;     // expected err
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  always @(negedge clk) if (sweep_done === 1'b1) done_cnt++;

  freq_sweep_ctrl #(
    .F_START    (20'd100),
    .F_STOP     (20'd104),
    .F_STEP     (20'd2),
    .SETTLE_CYC (24'd4),
    .AVG_LOG2   (1),
    .ADC_MIN    (12'd64),
    .RETUNE_CYC (28'd20)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .swipt_alive (swipt_alive),
    .start       (start),
    .retune_en   (retune_en),
    .adc         (adc),
    .adc_valid   (adc_valid),
    .freq_out    (freq_out),
    .best_adc    (best_adc),
    .busy        (busy),
    .locked      (locked),
    .sweep_done  (sweep_done),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int a0, input int a1, input int b0,
                         input int b1, input int c0, input int c1, input bit jk,
                         input int bst, input int fr, input bit lk, input bit er);
    vecs[i].s[0] = 12'(a0);
    vecs[i].s[1] = 12'(a1);
    vecs[i].s[2] = 12'(b0);
    vecs[i].s[3] = 12'(b1);
    vecs[i].s[4] = 12'(c0);
    vecs[i].s[5] = 12'(c1);
    vecs[i].junk = jk;
    vecs[i].best = bst;
    vecs[i].freq = fr;
    vecs[i].lk   = lk;
    vecs[i].er   = er;
  endtask

  // One complete sweep: 5 settle cycles, 2 samples, EVAL, STEP per point.
  task automatic run_sweep(input int idx, input bit do_start, input bit start_noise);
    int d0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    d0 = done_cnt;
    chk($sformatf("v%0d_busy_start", idx), busy, 1);
    chk($sformatf("v%0d_err_clr", idx), err, 0);
    chk($sformatf("v%0d_locked_low", idx), locked, 0);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("v%0d_freq_p%0d", idx, p), freq_out, 100 + 2 * p);
      for (int k = 0; k < 5; k++) begin
        adc_valid = vecs[idx].junk;
        adc       = 12'hFFF;
        start     = start_noise && (p == 1);
        tick();
      end
      start     = 1'b0;
      adc_valid = 1'b1;
      adc       = vecs[idx].s[2 * p];
      tick();
      adc       = vecs[idx].s[2 * p + 1];
      tick();
      adc_valid = 1'b0;
      adc       = '0;
      tick();
      tick();
    end
    chk($sformatf("v%0d_done", idx), sweep_done, 1);
    chk($sformatf("v%0d_freq_end", idx), freq_out, vecs[idx].freq);
    chk($sformatf("v%0d_best_adc", idx), best_adc, vecs[idx].best);
    chk($sformatf("v%0d_locked", idx), locked, int'(vecs[idx].lk));
    chk($sformatf("v%0d_err", idx), err, int'(vecs[idx].er));
    chk($sformatf("v%0d_busy_end", idx), busy, 0);
    tick();
    chk($sformatf("v%0d_done_drop", idx), sweep_done, 0);
    chk($sformatf("v%0d_done_count", idx), done_cnt - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int d0;

    //           p100      p102      p104     junk best  freq lk er
    set_vec(0, 200, 200, 300, 302, 250, 250, 1'b0, 301,  102, 1, 0);
    set_vec(1, 500, 500, 500, 500, 500, 500, 1'b1, 500,  100, 1, 0);
    set_vec(2,  10,  10,  10,  10,  10,  10, 1'b0,  10,  100, 0, 1);
    set_vec(3,  64,  64,  63,  63,  10,  10, 1'b0,  64,  100, 1, 0);
    set_vec(4,  63,  64,  62,  62,   0,   1, 1'b1,  63,  100, 0, 1);
    set_vec(5,   0,   0,4094,4095,4095,4095, 1'b0, 4095, 104, 1, 0);
    set_vec(6, 100, 100, 150, 151, 150, 150, 1'b0, 150,  102, 1, 0);

    // Reset state
    swipt_alive = 1'b1;
    tick();
    tick();
    chk("rst_freq", freq_out, 100);
    chk("rst_best_adc", best_adc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_err", err, 0);
    nrst = 1'b1;
    retune_en = 1'b1;
    tick();
    tick();
    chk("idle_no_start_busy", busy, 0);
    retune_en = 1'b0;

    // Table-driven full sweeps
    for (int i = 0; i < 7; i++) run_sweep(i, 1'b1, 1'b0);

    // Link loss in SETTLE at 102 together with a start request
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) tick();
    adc_valid = 1'b1;
    adc = 12'd400;
    tick();
    tick();
    adc_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_freq", freq_out, 102);
    tick();
    tick();
    swipt_alive = 1'b0;
    start = 1'b1;
    tick();
    chk("abort_freq", freq_out, 100);
    chk("abort_busy", busy, 0);
    chk("abort_locked", locked, 0);
    chk("abort_best_kept", best_adc, vecs[6].best);
    swipt_alive = 1'b1;
    start = 1'b0;
    tick();
    tick();
    chk("abort_idle_busy", busy, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    run_sweep(0, 1'b1, 1'b0);

    // Retune: retune_en dropped returns to LOCK, then a full countdown
    retune_en = 1'b1;
    tick();
    chk("wait_rt_locked", locked, 1);
    chk("wait_rt_busy", busy, 0);
    for (int k = 0; k < 5; k++) tick();
    retune_en = 1'b0;
    tick();
    for (int k = 0; k < 30; k++) tick();
    chk("rt_cancel_busy", busy, 0);
    chk("rt_cancel_locked", locked, 1);
    retune_en = 1'b1;
    tick();
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("retune_delay", n, 21);
    retune_en = 1'b0;
    if (busy === 1'b1) run_sweep(0, 1'b0, 1'b1);

    // Synchronous reset in ACCUM
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    adc_valid = 1'b1;
    adc = 12'd300;
    tick();
    nrst = 1'b0;
    adc = 12'd302;
    tick();
    chk("rst_mid_freq", freq_out, 100);
    chk("rst_mid_best_adc", best_adc, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_done", sweep_done, 0);
    chk("rst_mid_err", err, 0);
    nrst = 1'b1;
    adc_valid = 1'b0;
    adc = '0;
    tick();
    run_sweep(0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 Parameter F_START, 20'd100000, first sweep frequency (Hz).
REQ-002 Parameter F_STOP, 20'd120000, last permitted sweep frequency (Hz).
REQ-003 Parameter F_STEP, 20'd1000, sweep increment (Hz), nonzero.
REQ-004 Parameter SETTLE_CYC, 24'h30D40, settle cycles after every frequency change (2 ms).
REQ-005 Parameter AVG_LOG2, 3, log2 of ADC samples averaged per point (1..4).
REQ-006 Parameter ADC_MIN, 12'd64, minimum best average for a valid lock.
REQ-007 Parameter RETUNE_CYC, 28'd100000000, lock-to-resweep interval.
REQ-008 clk  in  1  system clock, rising edge.
REQ-009 nrst  in  1  reset, synchronous, active-low.
REQ-010 swipt_alive  in  1  link present; low aborts any activity.
REQ-011 start  in  1  one-cycle sweep request.
REQ-012 retune_en  in  1  enables periodic resweep from LOCK.
REQ-013 adc  in  12  rectified-voltage sample.
REQ-014 adc_valid  in  1  adc qualifier, one cycle per sample.
REQ-015 freq_out  out  20  frequency driven to the power stage.
REQ-016 best_adc  out  12  best averaged sample of the last completed sweep.
REQ-017 busy  out  1  high in SETTLE, ACCUM, EVAL, STEP.
REQ-018 locked  out  1  high in LOCK and WAIT_RT.
REQ-019 sweep_done  out  1  one-cycle pulse when a sweep completes (lock or error).
REQ-020 err  out  1  sticky: last sweep ended with best average < ADC_MIN.

Function
REQ-021 States: IDLE, SETTLE, ACCUM, EVAL, STEP, LOCK, WAIT_RT; all outputs registered.
REQ-022 IDLE: start=1 and swipt_alive=1 -> freq_out<=F_START, clear accumulator, best tracking and err, load settle counter, go SETTLE next cycle.
REQ-023 start outside IDLE/LOCK/WAIT_RT is ignored.
REQ-024 SETTLE: counter decrements each cycle; adc_valid ignored; at zero go ACCUM (SETTLE lasts exactly SETTLE_CYC+1 cycles).
REQ-025 ACCUM: each adc_valid adds adc into a (12+AVG_LOG2)-bit accumulator; after 2^AVG_LOG2 samples go EVAL.
REQ-026 EVAL (one cycle): avg = accumulator >> AVG_LOG2; if avg > best_avg strictly, capture best_avg and best_freq=freq_out; ties keep the earlier (lower) frequency.
REQ-027 STEP: next = freq_out + F_STEP computed in 21 bits; next <= F_STOP -> freq_out<=next, reload settle, clear accumulator, go SETTLE; else sweep ends.
REQ-028 Sweep end with best_avg >= ADC_MIN: freq_out<=best_freq, best_adc<=best_avg, err<=0, go LOCK, sweep_done pulses same cycle.
REQ-029 Sweep end with best_avg < ADC_MIN: freq_out<=F_START, best_adc<=best_avg, err<=1, go IDLE, sweep_done pulses.
REQ-030 LOCK: start=1 begins a new sweep as in IDLE; else retune_en=1 loads retune counter and goes WAIT_RT.
REQ-031 WAIT_RT: counter decrements; retune_en=0 returns to LOCK; at zero or on start, begin new sweep as in IDLE.
REQ-032 swipt_alive=0 in any state: next cycle IDLE, freq_out=F_START, counters and accumulator cleared, locked=0, no sweep_done; best_adc and err retained.
REQ-033 start and swipt_alive falling in the same cycle: abort wins.

Reset
REQ-034 nrst=0 at a rising edge: state IDLE, freq_out=F_START, best_adc=0, busy=0, locked=0, sweep_done=0, err=0, all counters and accumulator 0; overrides every other input, including mid-sweep.

Structure
REQ-035 Package freq_pkg holds the state enumeration, freq/ADC width constants and parameter defaults; shared with the existing frequency-tracking logic.
REQ-036 One sub-module freq_avg_accum (accumulate, sample count, shifted average, clear) is instantiated once; the FSM, settle and retune counters stay in freq_sweep_ctrl.

Verification (F_START=100, F_STOP=104, F_STEP=2, SETTLE_CYC=4, AVG_LOG2=1, ADC_MIN=64, RETUNE_CYC=20)
REQ-037 start; sample pairs per point 100:{200,200}, 102:{300,302}, 104:{250,250} -> freq_out 100,102,104 then 102; best_adc=301; sweep_done one pulse; locked=1; err=0.
REQ-038 Equal averages 500 at all points -> lock at 100 (first maximum kept).
REQ-039 All samples 10 -> err=1, freq_out=100, locked=0, state IDLE, one sweep_done.
REQ-040 swipt_alive low during SETTLE at 102 -> next cycle IDLE, freq_out=100, busy=0, no sweep_done; start reissued runs a full sweep.
REQ-041 Locked with retune_en=1 -> new sweep begins 21 cycles after WAIT_RT entry; start pulses during busy have no effect.
REQ-042 nrst=0 during ACCUM -> all outputs at reset values on the next edge; adc_valid pulses during SETTLE never change the result.
